serial_sum3: RTL and testbench



---
 rtl/serial_sum3.sv | 123 ++++++++++++
 tb/tb_serial_sum3.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_sum3.sv
// serial_sum3 -- bit-serial three-operand unsigned adder.
//
// Adds three WIDTH-bit operands one bit per clock, LSB first. Each bit
// position is a three-input full add plus a 2-bit carry (0..2), giving a
// WIDTH+2-bit result after WIDTH cycles.
//
// Optional feature: define SERIAL_SUM3_OVF_EN to add the ovf output. ovf is
// high when the result does not fit in WIDTH bits. It is registered together
// with sum.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    request, sampled only in IDLE or DONE
//   a, b, c  operands, captured on the accepting edge
//   busy     high while bits are being processed (RUN)
//   done     one-cycle pulse when sum has just been updated (DONE)
//   sum      last result a+b+c, held until the next result
//   ovf      (SERIAL_SUM3_OVF_EN only) sum[WIDTH+1:WIDTH] != 0
module serial_sum3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+1:0] sum
`ifdef SERIAL_SUM3_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, c_sh;
  logic [WIDTH-1:0] res_sh;
  logic [1:0]       carry;
  logic [CW-1:0]    cnt;
  logic [2:0]       t;
  logic             accept;
  logic             last;

  // Start is only looked at when no addition is in flight.
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  // Per-bit add: three operand bits plus the 2-bit carry, range 0..5.
  assign t = 3'(a_sh[0]) + 3'(b_sh[0]) + 3'(c_sh[0]) + 3'(carry);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry, bit counter, result accumulator.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      c_sh   <= '0;
      res_sh <= '0;
      carry  <= '0;
      cnt    <= '0;
      sum    <= '0;
`ifdef SERIAL_SUM3_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      c_sh  <= c;
      carry <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      c_sh   <= c_sh >> 1;
      // Result bits enter at the MSB so bit 0 ends up at res_sh[0].
      res_sh <= {t[0], res_sh[WIDTH-1:1]};
      carry  <= t[2:1];
      cnt    <= cnt + CW'(1);
      if (last) begin
        // res_sh is one shift short here, so the final bit is spliced in.
        sum <= {t[2:1], t[0], res_sh[WIDTH-1:1]};
`ifdef SERIAL_SUM3_OVF_EN
        ovf <= |t[2:1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sum3.sv
// Directed bench for serial_sum3: WIDTH=8 and WIDTH=2 instances share the
// clock and reset. Expected sums are hand-computed constants.
module tb_serial_sum3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, c8 = '0;
  logic       busy8, done8;
  logic [9:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, c2 = '0;
  logic       busy2, done2;
  logic [3:0] sum2;

`ifdef SERIAL_SUM3_OVF_EN
  logic ovf8, ovf2;
`endif

  serial_sum3 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8),
    .a(a8), .b(b8), .c(c8),
    .busy(busy8), .done(done8), .sum(sum8)
`ifdef SERIAL_SUM3_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sum3 #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .a(a2), .b(b2), .c(c2),
    .busy(busy2), .done(done2), .sum(sum2)
`ifdef SERIAL_SUM3_OVF_EN
    , .ovf(ovf2)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t_done = 0;
  logic [9:0] last_sum8 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One WIDTH=8 addition. pre: start/operands already driven by the caller.
  // hold: keep start high through RUN and disturb operands mid-run.
  // chain: leave start high with 100/100/100 in the DONE cycle and return.
  task automatic run8(input string tag, input logic [7:0] ia, ib, ic,
                      input bit hold, input bit pre, input bit chain,
                      input logic [9:0] exp_sum);
    int done_at = -1;
    int n_done  = 0;
    int n_busy  = 0;
    if (!pre) begin
      @(negedge clk);
      start8 = 1'b1; a8 = ia; b8 = ib; c8 = ic;
    end
    @(posedge clk);  // start edge
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      if (busy8) n_busy++;
      if (j == 0) chk({tag, ".sum_hold"}, 32'(sum8), 32'(last_sum8));
      if (done8) begin
        n_done++;
        if (done_at < 0) begin
          done_at = j;
          t_done  = cyc;
          chk({tag, ".sum"}, 32'(sum8), 32'(exp_sum));
`ifdef SERIAL_SUM3_OVF_EN
          chk({tag, ".ovf"}, 32'(ovf8), 32'(exp_sum[9:8] != 2'b00));
`endif
        end
      end
      if (hold && j == 2) begin a8 = 8'hAA; b8 = 8'hAA; c8 = 8'hAA; end
      if (!hold || j >= 8) start8 = 1'b0;
      if (chain && done8) begin
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd100; c8 = 8'd100;
        break;
      end
    end
    chk({tag, ".done_at"}, 32'(done_at), 32'd8);
    chk({tag, ".n_done"}, 32'(n_done), 32'd1);
    chk({tag, ".n_busy"}, 32'(n_busy), 32'd8);
    last_sum8 = exp_sum;
  endtask

  initial begin
    int n_done;
    int done_at;
    int n_busy;
    int t_first;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy8), 32'd0);
    chk("rst.done", 32'(done8), 32'd0);
    chk("rst.sum", 32'(sum8), 32'd0);
    chk("rst.sum2", 32'(sum2), 32'd0);
`ifdef SERIAL_SUM3_OVF_EN
    chk("rst.ovf", 32'(ovf8), 32'd0);
`endif
    reset_n = 1'b1;

    run8("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000);
    run8("max",  8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 10'h2FD);
    run8("hold", 8'd1,  8'd2,  8'd3,  1'b1, 1'b0, 1'b0, 10'd6);

    // Reset at start edge + 4 aborts the run.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd50; b8 = 8'd60; c8 = 8'd70;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort.busy", 32'(busy8), 32'd0);
    chk("abort.done", 32'(done8), 32'd0);
    chk("abort.sum", 32'(sum8), 32'd0);
`ifdef SERIAL_SUM3_OVF_EN
    chk("abort.ovf", 32'(ovf8), 32'd0);
`endif
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    chk("abort.n_done", 32'(n_done), 32'd0);
    chk("abort.sum_after", 32'(sum8), 32'd0);
    last_sum8 = '0;

    run8("after", 8'd5, 8'd6, 8'd7, 1'b0, 1'b0, 1'b0, 10'd18);

    // Back-to-back: second start in the DONE cycle.
    run8("b2b1", 8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 1'b1, 10'd60);
    t_first = t_done;
    run8("b2b2", 8'd100, 8'd100, 8'd100, 1'b0, 1'b1, 1'b0, 10'h12C);
    chk("b2b.gap", 32'(t_done - t_first), 32'd9);

    // WIDTH=2 corner.
    @(negedge clk);
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b11; c2 = 2'b11;
    @(posedge clk);
    done_at = -1;
    n_busy  = 0;
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (busy2) n_busy++;
      if (done2 && done_at < 0) begin
        done_at = j;
        chk("w2.sum", 32'(sum2), 32'd9);
`ifdef SERIAL_SUM3_OVF_EN
        chk("w2.ovf", 32'(ovf2), 32'd1);
`endif
      end
    end
    chk("w2.done_at", 32'(done_at), 32'd2);
    chk("w2.n_busy", 32'(n_busy), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
